// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer -- SDRAM command sequencer: init-sequence pulses
// (PRECHARGE / REFRESH / LOAD_MODE), hidden refresh, and single READA/WRITEA
// accesses with auto-precharge. Command pins are registered, one command per cycle.
// Build option: define SDRAM_REF_PREALL_EN to precede every hidden refresh
// with a precharge-all and a tRP wait.
module sdram_cmd_sequencer (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        NOP,
  input  logic        READA,
  input  logic        WRITEA,
  input  logic        REFRESH,
  input  logic        PRECHARGE,
  input  logic        LOAD_MODE,
  input  logic [21:0] SADDR,
  input  logic        REF_REQ,
  input  logic        INIT_REQ,
  output logic        REF_ACK,
  output logic        CM_ACK,
  output logic        OE,
  output logic [11:0] SA,
  output logic [1:0]  BA,
  output logic        CS_N,
  output logic        RAS_N,
  output logic        CAS_N,
  output logic        WE_N,
  output logic        CKE
);

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  // Wait-state counter loads. A wait state lasts (load + 1) cycles; together
  // with the one-cycle command state this gives the command-to-command spacing
  // (tRCD 3, tRP 3, tRFC 8, tMRD 2). The post-RD/WR gap is 12 NOP cycles.
  localparam logic [3:0]  RCD_LD     = 4'd1;
  localparam logic [3:0]  RP_LD      = 4'd1;
  localparam logic [3:0]  RFC_LD     = 4'd6;
  localparam logic [3:0]  MRD_LD     = 4'd0;
  localparam logic [3:0]  GAP_LD     = 4'd11;
  localparam logic [2:0]  OE_LD      = 3'd7;    // 8-beat write burst
  localparam logic [11:0] SA_ALLBANK = 12'h400; // A10 = all banks / auto-precharge

  typedef enum logic [3:0] {
    ST_IDLE, ST_ACT, ST_RCD_WAIT, ST_RDWR, ST_BURST_WAIT, ST_PREALL,
    ST_RP_WAIT, ST_AREF, ST_RFC_WAIT, ST_MRS, ST_MRD_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [11:0] sa_q, sa_d;
  logic [1:0]  ba_q, ba_d;
  logic        ref_ack_q, ref_ack_d;
  logic        cm_ack_q, cm_ack_d;
  logic        oe_q, oe_d;
  logic [2:0]  oe_cnt_q, oe_cnt_d;
  logic        cke_q;
  logic [1:0]  bank_q, bank_d;
  logic [7:0]  col_q, col_d;
  logic        wr_q, wr_d;
`ifdef SDRAM_REF_PREALL_EN
  logic        hidden_q, hidden_d;  // current PREALL belongs to a hidden refresh
`endif

  logic rw_req;
  logic wr_start;

  assign rw_req   = (READA | WRITEA) & ~NOP;
  assign wr_start = (state_q == ST_RCD_WAIT) && (cnt_q == 4'd0) && wr_q;

  // Next-state and next-pin logic; commands are only accepted in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = CMD_NOP;
    sa_d      = sa_q;
    ba_d      = ba_q;
    ref_ack_d = 1'b0;
    cm_ack_d  = 1'b0;
    bank_d    = bank_q;
    col_d     = col_q;
    wr_d      = wr_q;
`ifdef SDRAM_REF_PREALL_EN
    hidden_d  = hidden_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (PRECHARGE) begin
          state_d = ST_PREALL;
          cmd_d   = CMD_PRE;
          sa_d    = SA_ALLBANK;
`ifdef SDRAM_REF_PREALL_EN
          hidden_d = 1'b0;
`endif
        end else if (REFRESH) begin
          state_d = ST_AREF;
          cmd_d   = CMD_REF;
        end else if (LOAD_MODE) begin
          state_d = ST_MRS;
          cmd_d   = CMD_MRS;
          sa_d    = SADDR[11:0];
          ba_d    = 2'b00;
        end else if (REF_REQ && !INIT_REQ) begin
`ifdef SDRAM_REF_PREALL_EN
          state_d  = ST_PREALL;
          cmd_d    = CMD_PRE;
          sa_d     = SA_ALLBANK;
          hidden_d = 1'b1;
`else
          state_d   = ST_AREF;
          cmd_d     = CMD_REF;
          ref_ack_d = 1'b1;
`endif
        end else if (rw_req) begin
          // Address is captured here; later SADDR changes are ignored.
          state_d = ST_ACT;
          cmd_d   = CMD_ACT;
          sa_d    = SADDR[19:8];
          ba_d    = SADDR[21:20];
          bank_d  = SADDR[21:20];
          col_d   = SADDR[7:0];
          wr_d    = ~READA;
        end
      end
      ST_ACT: begin
        state_d = ST_RCD_WAIT;
        cnt_d   = RCD_LD;
      end
      ST_RCD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_RDWR;
          cmd_d    = wr_q ? CMD_WRITE : CMD_READ;
          sa_d     = {2'b01, 2'b00, col_q};
          ba_d     = bank_q;
          cm_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RDWR: begin
        state_d = ST_BURST_WAIT;
        cnt_d   = GAP_LD;
      end
      ST_PREALL: begin
        state_d = ST_RP_WAIT;
        cnt_d   = RP_LD;
      end
      ST_RP_WAIT: begin
        if (cnt_q == 4'd0) begin
`ifdef SDRAM_REF_PREALL_EN
          if (hidden_q) begin
            state_d   = ST_AREF;
            cmd_d     = CMD_REF;
            ref_ack_d = 1'b1;
            hidden_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_AREF: begin
        state_d = ST_RFC_WAIT;
        cnt_d   = RFC_LD;
      end
      ST_MRS: begin
        state_d = ST_MRD_WAIT;
        cnt_d   = MRD_LD;
      end
      ST_BURST_WAIT, ST_RFC_WAIT, ST_MRD_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write-data enable: high for 8 cycles starting with the WRITE command cycle.
  always_comb begin
    oe_d     = oe_q;
    oe_cnt_d = oe_cnt_q;
    if (wr_start) begin
      oe_d     = 1'b1;
      oe_cnt_d = OE_LD;
    end else if (oe_q) begin
      if (oe_cnt_q == 3'd0) oe_d     = 1'b0;
      else                  oe_cnt_d = oe_cnt_q - 3'd1;
    end
  end

  // State, pin and capture registers; reset deselects the device with CKE low.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= CMD_DESEL;
      sa_q      <= '0;
      ba_q      <= '0;
      ref_ack_q <= 1'b0;
      cm_ack_q  <= 1'b0;
      oe_q      <= 1'b0;
      oe_cnt_q  <= '0;
      cke_q     <= 1'b0;
      bank_q    <= '0;
      col_q     <= '0;
      wr_q      <= 1'b0;
`ifdef SDRAM_REF_PREALL_EN
      hidden_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      sa_q      <= sa_d;
      ba_q      <= ba_d;
      ref_ack_q <= ref_ack_d;
      cm_ack_q  <= cm_ack_d;
      oe_q      <= oe_d;
      oe_cnt_q  <= oe_cnt_d;
      cke_q     <= 1'b1;
      bank_q    <= bank_d;
      col_q     <= col_d;
      wr_q      <= wr_d;
`ifdef SDRAM_REF_PREALL_EN
      hidden_q  <= hidden_d;
`endif
    end
  end

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
  assign SA      = sa_q;
  assign BA      = ba_q;
  assign CKE     = cke_q;
  assign OE      = oe_q;
  assign REF_ACK = ref_ack_q;
  assign CM_ACK  = cm_ack_q;

endmodule
